mw_ecc_encode_reg: RTL
======================

# mw_ecc_encode_reg

Memory-to-writeback pipeline register and the encoding end of the writeback ECC path. It Hamming-SECDED-encodes the ALU result, the load data and PC+4 into 39-bit codewords and registers them. It also registers the writeback control fields. A self-check engine verifies every captured word one cycle after capture, and a fault-injection port lets BIST corrupt a single bit on purpose.

## Interface
Parameters:
- CNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  load M-stage values this cycle
- flush  in  1  load bubble (zero codewords, RegWriteW=0)
- RegWriteM  in  1  register-write control
- ResultSrcM  in  1  result select (0=ALU, 1=load data)
- RdM  in  5  destination register
- ALU_ResultM, ReadDataM, PCPlus4M  in  32 each  raw data
- inj_en  in  1  fault injection on this load
- inj_sel  in  2  field: 0=ALU, 1=ReadData, 2=PCPlus4, 3=none
- inj_pos  in  6  codeword bit to flip (0..38)
- err_clr  in  1  clear sticky flag and counter
- RegWriteW, ResultSrcW  out  1 each  registered control
- RdW  out  5  registered destination
- ALU_ResultW_ECC, ReadDataW_ECC, PCPlus4W_ECC  out  39 each  registered codewords
- ecc_err_field  out  3  per-field check result of last check ({PC4,RD,ALU})
- ecc_chk_error  out  1  sticky: any check failed
- ecc_err_count  out  CNT_W  failed-check count, saturating

## Operation
- Codeword layout is shared with hamming_ecc_unit:
  - Bits [38:1] are Hamming positions 1..38.
  - Parity bits sit at positions 1, 2, 4, 8, 16 and 32. Parity at position 2^k is even parity over all positions with bit k set.
  - Data d0..d31 fill the remaining positions in ascending order.
  - Bit 0 is even parity over bits [38:1].
- Update priority per edge: rst > flush > en > hold.
  - rst: all outputs 0 (zero codewords are valid encodings of 0), chk_pend=0.
  - flush: codewords=0, RegWriteW=0, ResultSrcW=0, RdW=0. Counts as a load.
  - en: encode the three inputs and capture them with the control fields.
  - Otherwise: all registers hold.
- Injection applies only on an en load (not flush).
  - The bit at inj_pos in the inj_sel field is inverted after encoding.
  - inj_pos >= 39 or inj_sel=3: no effect.
- Self-check engine:
  - chk_pend <= (load this cycle).
  - On an edge with chk_pend=1, each held codeword is re-checked. A field fails if its syndrome is nonzero or its overall parity is odd.
  - ecc_err_field <= fail vector.
  - If any bit fails: ecc_chk_error <= 1 and ecc_err_count increments by 1, saturating at 2^CNT_W−1.
  - With chk_pend=0, ecc_err_field holds. Held words are not re-counted.
- err_clr clears ecc_chk_error, ecc_err_count and ecc_err_field. rst has priority over err_clr.
  - If a check fails on the same edge as err_clr, the check wins: flag=1, count=1, field=vector.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on the W outputs after edge N.
- The check result for a word loaded at edge N appears after edge N+1.
- Back-to-back loads are checked every cycle with no bubble; each edge checks the contents captured on the previous edge.
- Reset mid-operation discards any pending check: the count is not incremented and chk_pend=0.
- Encoding is purely combinational before the register. There are no multi-cycle paths.

## Test plan
- Reset, then en=1 with ALU_ResultM=0x00000001 and other data 0 -> ALU_ResultW_ECC=39'h000000000F, others 0. One edge later: ecc_err_field=0, count=0.
- en=1, inj_en=1, inj_sel=1, inj_pos=5, ReadDataM=0 -> ReadDataW_ECC=39'h0000000020. Next edge: ecc_err_field=3'b010, ecc_chk_error=1, count=1.
- Hold the injected word for 10 cycles with en=0 -> count stays 1. Then load 300 consecutive injected words -> count saturates at 255.
- flush=1 together with en=1 and inj_en=1 -> all codewords 0, RegWriteW=0, and no error on the following check.
- inj_pos=45 with inj_sel=0 -> codeword is a correct encoding and the check passes. err_clr while a failing check is pending -> flag=1, count=1.
- rst asserted the cycle after an injected load -> all outputs 0 and count stays 0.

Source files
------------

// File: rtl/mw_ecc_encode_reg.sv
// mw_ecc_encode_reg: M->W pipeline register that SECDED-encodes ALU result,
// load data and PC+4 into 39-bit codewords. The block also has a one-cycle
// self-check engine and a BIST single-bit fault-injection port.
module mw_ecc_encode_reg #(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RdM,
  input  logic [31:0]       ALU_ResultM,
  input  logic [31:0]       ReadDataM,
  input  logic [31:0]       PCPlus4M,
  input  logic              inj_en,
  input  logic [1:0]        inj_sel,
  input  logic [5:0]        inj_pos,
  input  logic              err_clr,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RdW,
  output logic [38:0]       ALU_ResultW_ECC,
  output logic [38:0]       ReadDataW_ECC,
  output logic [38:0]       PCPlus4W_ECC,
  output logic [2:0]        ecc_err_field,
  output logic              ecc_chk_error,
  output logic [CNT_W-1:0]  ecc_err_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CW_W   = 39;
  localparam int unsigned SYN_W  = 6;
  localparam int unsigned NPOS   = 38;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Syndrome over Hamming positions 1..38: XOR of the indices of all set bits.
  function automatic logic [SYN_W-1:0] ecc_syndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int unsigned i = 1; i <= NPOS; i++) begin
      if (cw[i]) s = s ^ SYN_W'(i);
    end
    return s;
  endfunction

  // Scatter data into non-power-of-two positions, then set parity and overall bit.
  function automatic logic [CW_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0]  cw;
    logic [SYN_W-1:0] s;
    logic [4:0]       j;
    cw = '0;
    j  = '0;
    for (int unsigned i = 1; i <= NPOS; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[j];
        j     = j + 5'd1;
      end
    end
    s      = ecc_syndrome(cw);
    cw[1]  = s[0];
    cw[2]  = s[1];
    cw[4]  = s[2];
    cw[8]  = s[3];
    cw[16] = s[4];
    cw[32] = s[5];
    cw[0]  = ^cw[CW_W-1:1];
    return cw;
  endfunction

  // A word fails if its syndrome is nonzero or its overall parity is odd.
  function automatic logic ecc_fail(input logic [CW_W-1:0] cw);
    return (ecc_syndrome(cw) != '0) || (^cw);
  endfunction

  logic             regwrite_q, regwrite_d;
  logic             resultsrc_q, resultsrc_d;
  logic [4:0]       rd_q, rd_d;
  logic [CW_W-1:0]  alu_cw_q, alu_cw_d;
  logic [CW_W-1:0]  rdata_cw_q, rdata_cw_d;
  logic [CW_W-1:0]  pc4_cw_q, pc4_cw_d;
  logic             chk_pend_q, chk_pend_d;
  logic [2:0]       err_field_q, err_field_d;
  logic             chk_error_q, chk_error_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [CW_W-1:0]  inj_mask_c;
  logic [2:0]       fail_vec_c;

  // Single-bit injection mask; out-of-range positions produce no flip.
  always_comb begin
    inj_mask_c = '0;
    if (inj_en && (inj_pos < 6'(CW_W))) inj_mask_c = CW_W'(1) << inj_pos;
  end

  // Pipeline data path: flush > en > hold.
  always_comb begin
    regwrite_d  = regwrite_q;
    resultsrc_d = resultsrc_q;
    rd_d        = rd_q;
    alu_cw_d    = alu_cw_q;
    rdata_cw_d  = rdata_cw_q;
    pc4_cw_d    = pc4_cw_q;
    if (flush) begin
      regwrite_d  = 1'b0;
      resultsrc_d = 1'b0;
      rd_d        = '0;
      alu_cw_d    = '0;
      rdata_cw_d  = '0;
      pc4_cw_d    = '0;
    end else if (en) begin
      regwrite_d  = RegWriteM;
      resultsrc_d = ResultSrcM;
      rd_d        = RdM;
      alu_cw_d    = ecc_encode(ALU_ResultM);
      rdata_cw_d  = ecc_encode(ReadDataM);
      pc4_cw_d    = ecc_encode(PCPlus4M);
      case (inj_sel)
        2'd0:    alu_cw_d   = alu_cw_d ^ inj_mask_c;
        2'd1:    rdata_cw_d = rdata_cw_d ^ inj_mask_c;
        2'd2:    pc4_cw_d   = pc4_cw_d ^ inj_mask_c;
        default: ;
      endcase
    end
  end

  // Self-check of the words captured on the previous edge; a failing check beats err_clr.
  always_comb begin
    chk_pend_d  = flush | en;
    err_field_d = err_field_q;
    chk_error_d = chk_error_q;
    err_count_d = err_count_q;
    fail_vec_c  = {ecc_fail(pc4_cw_q), ecc_fail(rdata_cw_q), ecc_fail(alu_cw_q)};
    if (err_clr) begin
      err_field_d = '0;
      chk_error_d = 1'b0;
      err_count_d = '0;
    end
    if (chk_pend_q) begin
      err_field_d = fail_vec_c;
      if (|fail_vec_c) begin
        chk_error_d = 1'b1;
        if (err_clr)                     err_count_d = CNT_W'(1);
        else if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      alu_cw_q    <= '0;
      rdata_cw_q  <= '0;
      pc4_cw_q    <= '0;
      chk_pend_q  <= 1'b0;
      err_field_q <= '0;
      chk_error_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      alu_cw_q    <= alu_cw_d;
      rdata_cw_q  <= rdata_cw_d;
      pc4_cw_q    <= pc4_cw_d;
      chk_pend_q  <= chk_pend_d;
      err_field_q <= err_field_d;
      chk_error_q <= chk_error_d;
      err_count_q <= err_count_d;
    end
  end

  assign RegWriteW       = regwrite_q;
  assign ResultSrcW      = resultsrc_q;
  assign RdW             = rd_q;
  assign ALU_ResultW_ECC = alu_cw_q;
  assign ReadDataW_ECC   = rdata_cw_q;
  assign PCPlus4W_ECC    = pc4_cw_q;
  assign ecc_err_field   = err_field_q;
  assign ecc_chk_error   = chk_error_q;
  assign ecc_err_count   = err_count_q;

endmodule
